// File: rtl/turn_controller.sv
// Turn sequencer for the two-player tank game: gates movement to the active
// tank, runs the fire handshake, tracks health and declares the winner.
module turn_controller #(
  parameter int unsigned MOVE_BUDGET   = 64,
  parameter int unsigned TURN_TIMEOUT  = 600,
  parameter int unsigned SETTLE_FRAMES = 30,
  parameter int unsigned START_HEALTH  = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       fire_ack,
  input  logic       shot_done,
  input  logic       hit1,
  input  logic       hit2,
  output logic       active,
  output logic       move_l,
  output logic       move_r,
  output logic       fire_req,
  output logic [1:0] health1,
  output logic [1:0] health2,
  output logic [7:0] budget,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned KEY_W    = 8;
  localparam int unsigned TIMER_W  = 10;
  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned HEALTH_W = 2;
  localparam int unsigned BUDGET_W = 8;

  localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h04;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h07;
  localparam logic [KEY_W-1:0] KEY_FIRE  = 8'h2C;
  localparam logic [KEY_W-1:0] KEY_START = 8'h28;

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TURN_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
  localparam logic [BUDGET_W-1:0] BUDGET_INIT = BUDGET_W'(MOVE_BUDGET);
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(START_HEALTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_FIRE,
    S_FLIGHT,
    S_SETTLE,
    S_SWITCH,
    S_OVER
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [KEY_W-1:0]      r_prev_key;
  logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
  logic [SETTLE_W-1:0]   r_settle, w_settle_nxt;
  logic                  r_active, w_active_nxt;
  logic                  r_move_l, w_move_l_nxt;
  logic                  r_move_r, w_move_r_nxt;
  logic                  r_fire_req, w_fire_req_nxt;
  logic [HEALTH_W-1:0]   r_health1, w_health1_nxt;
  logic [HEALTH_W-1:0]   r_health2, w_health2_nxt;
  logic [BUDGET_W-1:0]   r_budget, w_budget_nxt;
  logic                  r_game_over, w_game_over_nxt;
  logic [1:0]            r_winner, w_winner_nxt;
  logic                  w_fire_edge;

  // A held space bar produces only one shot.
  assign w_fire_edge = (keycode == KEY_FIRE) && (r_prev_key != KEY_FIRE);

  always_ff @(posedge frame_clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_settle_nxt    = r_settle;
    w_active_nxt    = r_active;
    w_move_l_nxt    = 1'b0;
    w_move_r_nxt    = 1'b0;
    w_fire_req_nxt  = r_fire_req;
    w_health1_nxt   = r_health1;
    w_health2_nxt   = r_health2;
    w_budget_nxt    = r_budget;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;

    case (r_state)
      S_IDLE: begin
        if (keycode == KEY_START) begin
          w_budget_nxt = BUDGET_INIT;
          w_timer_nxt  = '0;
          w_active_nxt = 1'b0;
          w_state_nxt  = S_MOVE;
        end
      end
      S_MOVE: begin
        w_timer_nxt = r_timer + TIMER_W'(1);
        if (w_fire_edge) begin
          w_fire_req_nxt = 1'b1;
          w_state_nxt    = S_FIRE;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = S_SWITCH;
        end else if (r_budget != '0) begin
          // Strobes only when staying in MOVE, so they never leak into SWITCH.
          if (keycode == KEY_LEFT) begin
            w_move_l_nxt = 1'b1;
            w_budget_nxt = r_budget - BUDGET_W'(1);
          end else if (keycode == KEY_RIGHT) begin
            w_move_r_nxt = 1'b1;
            w_budget_nxt = r_budget - BUDGET_W'(1);
          end
        end
      end
      S_FIRE: begin
        if (fire_ack) begin
          w_fire_req_nxt = 1'b0;
          w_state_nxt    = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (shot_done) begin
          if (hit1 && (r_health1 != '0)) w_health1_nxt = r_health1 - HEALTH_W'(1);
          if (hit2 && (r_health2 != '0)) w_health2_nxt = r_health2 - HEALTH_W'(1);
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          if ((r_health1 == '0) || (r_health2 == '0)) begin
            w_game_over_nxt = 1'b1;
            if ((r_health1 == '0) && (r_health2 == '0)) w_winner_nxt = 2'b11;
            else if (r_health2 == '0)                  w_winner_nxt = 2'b01;
            else                                       w_winner_nxt = 2'b10;
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt = S_SWITCH;
          end
        end else begin
          w_settle_nxt = r_settle + SETTLE_W'(1);
        end
      end
      S_SWITCH: begin
        w_active_nxt = ~r_active;
        w_budget_nxt = BUDGET_INIT;
        w_timer_nxt  = '0;
        w_state_nxt  = S_MOVE;
      end
      S_OVER: begin
        // Restart restores reset values but skips IDLE.
        if (keycode == KEY_START) begin
          w_active_nxt    = 1'b0;
          w_fire_req_nxt  = 1'b0;
          w_health1_nxt   = HEALTH_INIT;
          w_health2_nxt   = HEALTH_INIT;
          w_budget_nxt    = '0;
          w_game_over_nxt = 1'b0;
          w_winner_nxt    = 2'b00;
          w_timer_nxt     = '0;
          w_settle_nxt    = '0;
          w_state_nxt     = S_MOVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      r_prev_key  <= '0;
      r_timer     <= '0;
      r_settle    <= '0;
      r_active    <= 1'b0;
      r_move_l    <= 1'b0;
      r_move_r    <= 1'b0;
      r_fire_req  <= 1'b0;
      r_health1   <= HEALTH_INIT;
      r_health2   <= HEALTH_INIT;
      r_budget    <= '0;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
    end else begin
      r_prev_key  <= keycode;
      r_timer     <= w_timer_nxt;
      r_settle    <= w_settle_nxt;
      r_active    <= w_active_nxt;
      r_move_l    <= w_move_l_nxt;
      r_move_r    <= w_move_r_nxt;
      r_fire_req  <= w_fire_req_nxt;
      r_health1   <= w_health1_nxt;
      r_health2   <= w_health2_nxt;
      r_budget    <= w_budget_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign active    = r_active;
  assign move_l    = r_move_l;
  assign move_r    = r_move_r;
  assign fire_req  = r_fire_req;
  assign health1   = r_health1;
  assign health2   = r_health2;
  assign budget    = r_budget;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed game scenarios plus random play, all
// compared every frame against a behavioural model of the turn rules.
module tb_turn_controller;

  localparam int MB = 64;
  localparam int TO = 600;
  localparam int SF = 30;
  localparam int SH = 3;

  localparam int M_IDLE   = 0;
  localparam int M_MOVE   = 1;
  localparam int M_FIRE   = 2;
  localparam int M_FLIGHT = 3;
  localparam int M_SETTLE = 4;
  localparam int M_SWITCH = 5;
  localparam int M_OVER   = 6;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic       fire_ack  = 1'b0;
  logic       shot_done = 1'b0;
  logic       hit1      = 1'b0;
  logic       hit2      = 1'b0;
  logic       active, move_l, move_r, fire_req, game_over;
  logic [1:0] health1, health2, winner;
  logic [7:0] budget;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_mr   = 0;
  int cnt_freq = 0;

  // reference model
  int m_mode, m_prev, m_frames, m_settle_left;
  int m_active, m_ml, m_mr, m_freq, m_h1, m_h2, m_budget, m_go, m_win;

  turn_controller dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .fire_ack  (fire_ack),
    .shot_done (shot_done),
    .hit1      (hit1),
    .hit2      (hit2),
    .active    (active),
    .move_l    (move_l),
    .move_r    (move_r),
    .fire_req  (fire_req),
    .health1   (health1),
    .health2   (health2),
    .budget    (budget),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_prev = 0; m_frames = 0; m_settle_left = 0;
    m_active = 0; m_ml = 0; m_mr = 0; m_freq = 0;
    m_h1 = SH; m_h2 = SH; m_budget = 0; m_go = 0; m_win = 0;
  endtask

  task automatic model_step();
    bit fe;
    int key;
    if (!Reset) begin
      model_reset();
      return;
    end
    key = int'(keycode);
    fe = (key == 8'h2C) && (m_prev != 8'h2C);
    m_prev = key;
    m_ml = 0;
    m_mr = 0;
    case (m_mode)
      M_IDLE: if (key == 8'h28) begin
        m_budget = MB; m_frames = 0; m_active = 0; m_mode = M_MOVE;
      end
      M_MOVE: begin
        m_frames++;
        if (fe) begin
          m_freq = 1; m_mode = M_FIRE;
        end else if (m_frames == TO) begin
          m_mode = M_SWITCH;
        end else if (m_budget > 0 && key == 8'h04) begin
          m_ml = 1; m_budget--;
        end else if (m_budget > 0 && key == 8'h07) begin
          m_mr = 1; m_budget--;
        end
      end
      M_FIRE: if (fire_ack) begin
        m_freq = 0; m_mode = M_FLIGHT;
      end
      M_FLIGHT: if (shot_done) begin
        if (hit1 && m_h1 > 0) m_h1--;
        if (hit2 && m_h2 > 0) m_h2--;
        m_settle_left = SF;
        m_mode = M_SETTLE;
      end
      M_SETTLE: begin
        m_settle_left--;
        if (m_settle_left == 0) begin
          if (m_h1 == 0 || m_h2 == 0) begin
            m_go = 1;
            m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h2 == 0 ? 1 : 2);
            m_mode = M_OVER;
          end else begin
            m_mode = M_SWITCH;
          end
        end
      end
      M_SWITCH: begin
        m_active = 1 - m_active; m_budget = MB; m_frames = 0; m_mode = M_MOVE;
      end
      M_OVER: if (key == 8'h28) begin
        m_active = 0; m_freq = 0; m_h1 = SH; m_h2 = SH; m_budget = 0;
        m_go = 0; m_win = 0; m_frames = 0; m_mode = M_MOVE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One frame: model sees the same inputs as the DUT edge, outputs compared 1 later.
  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
    check("active",    32'(active),    32'(m_active));
    check("move_l",    32'(move_l),    32'(m_ml));
    check("move_r",    32'(move_r),    32'(m_mr));
    check("fire_req",  32'(fire_req),  32'(m_freq));
    check("health1",   32'(health1),   32'(m_h1));
    check("health2",   32'(health2),   32'(m_h2));
    check("budget",    32'(budget),    32'(m_budget));
    check("game_over", 32'(game_over), 32'(m_go));
    check("winner",    32'(winner),    32'(m_win));
    cnt_mr   += int'(move_r);
    cnt_freq += int'(fire_req);
  endtask

  task automatic do_shot(input bit a, input bit b);
    int n;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    n = 0;
    while (fire_req !== 1'b1 && n < 10) begin tick(); n++; end
    check("fire_req_wait", 32'(fire_req), 32'd1);
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    tick(); tick();
    shot_done = 1'b1; hit1 = a; hit2 = b; tick();
    shot_done = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
    repeat (SF + 1) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // reset
    Reset = 1'b0; tick(); tick();
    check("rst_health1", 32'(health1), 32'd3);
    check("rst_budget",  32'(budget),  32'd0);
    Reset = 1'b1;

    // enter then hold right for 70 frames
    keycode = 8'h28; tick();
    keycode = 8'h07; cnt_mr = 0;
    repeat (70) tick();
    check("move_r_pulses", 32'(cnt_mr), 32'd64);
    check("budget_spent",  32'(budget), 32'd0);
    check("active_t1",     32'(active), 32'd0);

    // space held 10 frames, ack on the fourth
    cnt_freq = 0;
    for (int i = 0; i < 10; i++) begin
      keycode = 8'h2C; fire_ack = (i == 3); tick();
    end
    fire_ack = 1'b0; keycode = 8'h00;
    check("fire_req_cycles", 32'(cnt_freq), 32'd3);
    tick(); tick();
    shot_done = 1'b1; tick(); shot_done = 1'b0;
    repeat (SF) tick();
    check("active_before_switch", 32'(active), 32'd0);
    tick();
    check("active_after_settle", 32'(active), 32'd1);
    check("budget_reload",       32'(budget), 32'd64);

    // timeout with no keys
    cnt_freq = 0;
    repeat (TO) tick();
    check("active_at_timeout", 32'(active), 32'd1);
    tick();
    check("timeout_no_fire",   32'(cnt_freq), 32'd0);
    check("timeout_active",    32'(active),   32'd0);
    check("timeout_budget",    32'(budget),   32'd64);

    // three hits on tank 2
    for (int i = 0; i < 3; i++) begin
      do_shot(1'b0, 1'b1);
      check("health2_step", 32'(health2), 32'(2 - i));
    end
    check("go_t1",     32'(game_over), 32'd1);
    check("winner_t1", 32'(winner),    32'd1);

    // restart, then a draw
    keycode = 8'h28; tick(); keycode = 8'h00;
    check("restart_h1",     32'(health1),   32'd3);
    check("restart_h2",     32'(health2),   32'd3);
    check("restart_active", 32'(active),    32'd0);
    check("restart_go",     32'(game_over), 32'd0);
    for (int i = 0; i < 3; i++) do_shot(1'b1, 1'b1);
    check("draw_winner", 32'(winner),    32'd3);
    check("draw_go",     32'(game_over), 32'd1);
    keycode = 8'h28; tick(); keycode = 8'h00;
    check("draw_restart_h1",     32'(health1), 32'd3);
    check("draw_restart_active", 32'(active),  32'd0);

    // random play
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    keycode = 8'h04;
        2, 3:    keycode = 8'h07;
        4:       keycode = 8'h2C;
        5:       keycode = 8'h28;
        6:       keycode = 8'($urandom_range(0, 255));
        default: keycode = 8'h00;
      endcase
      fire_ack  = ($urandom_range(0, 3) == 0);
      shot_done = ($urandom_range(0, 7) == 0);
      hit1      = 1'($urandom_range(0, 1));
      hit2      = 1'($urandom_range(0, 1));
      Reset     = ($urandom_range(0, 499) != 0);
      tick();
    end
    fire_ack = 1'b0; shot_done = 1'b0; hit1 = 1'b0; hit2 = 1'b0; keycode = 8'h00;

    // reset in the middle of FIRE
    Reset = 1'b0; tick(); Reset = 1'b1;
    keycode = 8'h28; tick();
    keycode = 8'h2C; tick(); keycode = 8'h00;
    check("in_fire_req", 32'(fire_req), 32'd1);
    Reset = 1'b0; tick(); Reset = 1'b1;
    check("rst_fire_req", 32'(fire_req), 32'd0);
    check("rst_budget2",  32'(budget),   32'd0);
    check("rst_active",   32'(active),   32'd0);
    shot_done = 1'b1; hit1 = 1'b1; hit2 = 1'b1; tick();
    shot_done = 1'b0; hit1 = 1'b0; hit2 = 1'b0; tick();
    check("stray_h1", 32'(health1), 32'd3);
    check("stray_h2", 32'(health2), 32'd3);
    keycode = 8'h2C; tick(); keycode = 8'h00;
    check("idle_no_fire", 32'(fire_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
